// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the core run/step controller.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    STEP_WAIT,
    STEP_PULSE,
    DONE
  } run_state_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    STEP  = 2'd1,
    RUN_N = 2'd2
  } run_mode_t;

  // The reserved encoding 3 behaves as a free run.
  function automatic run_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return STEP;
      2'd2:    return RUN_N;
      default: return FREE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_clk_en_div.sv
// Free-running clock-enable divider: tick is high one cycle in every DIV.
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);

  // Tick is registered from the next count so it is low during reset even when DIV is 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the ARM core: reset sequencing, clock-enable gating
// (free, N-cycle or single-step) and the pixel-clock enable.
//
// state      | meaning
// IDLE       | core held in reset, waiting for start
// RESET      | core reset asserted for RESET_HOLD cycles
// RUN        | core enabled every cycle (FREE or RUN_N)
// STEP_WAIT  | core frozen, waiting for a step request
// STEP_PULSE | single enabled cycle for one step
// DONE       | core out of reset but frozen for inspection
module cpu_run_ctrl #(
  parameter int RESET_HOLD = 2,
  parameter int CNT_W      = 32,
  parameter int PIX_DIV    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic             step,
  input  logic             halt,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic             pix_ce,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  import cpu_run_pkg::*;

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD - 1);

  run_state_t       r_state;
  run_mode_t        r_mode;
  logic [CNT_W-1:0] r_remain;
  logic [HW-1:0]    r_hold;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_inc;

  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  // Run sequencer; r_remain counts down the RUN_N budget and r_hold the reset window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_mode   <= FREE;
      r_remain <= '0;
      r_hold   <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= RESET;
            r_mode   <= decode_mode(mode);
            r_remain <= n_cycles;
            r_hold   <= HOLD_INIT;
            r_count  <= '0;
          end
        end
        RESET: begin
          if (r_hold == '0) begin
            if (r_mode == STEP)
              r_state <= STEP_WAIT;
            else if (r_mode == RUN_N && r_remain == '0)
              r_state <= DONE;
            else
              r_state <= RUN;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        RUN: begin
          r_count <= w_count_inc;
          if (r_mode == RUN_N)
            r_remain <= r_remain - CNT_W'(1);
          if (halt || (r_mode == RUN_N && r_remain == CNT_W'(1)))
            r_state <= DONE;
        end
        STEP_WAIT: begin
          if (halt)
            r_state <= DONE;
          else if (step)
            r_state <= STEP_PULSE;
        end
        STEP_PULSE: begin
          r_count <= w_count_inc;
          r_state <= halt ? DONE : STEP_WAIT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_rst     = (r_state == IDLE) || (r_state == RESET);
  assign cpu_ce      = (r_state == RUN) || (r_state == STEP_PULSE);
  assign busy        = (r_state == RESET) || (r_state == RUN) ||
                       (r_state == STEP_WAIT) || (r_state == STEP_PULSE);
  assign done        = (r_state == DONE);
  assign cycle_count = r_count;

  clk_en_div #(.DIV(PIX_DIV)) u_pix_div (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_ce)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three instances (PIX_DIV 2/5/1, CNT_W 32/4/8) share stimulus.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] n_cycles = 32'd0;

  logic        a_rst, a_ce, a_pix, a_busy, a_done;
  logic [31:0] a_cnt;
  logic        b_rst, b_ce, b_pix, b_busy, b_done;
  logic [3:0]  b_cnt;
  logic        c_rst, c_ce, c_pix, c_busy, c_done;
  logic [7:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        r;
    logic        ce;
    logic        b;
    logic        d;
    logic [31:0] cnt;
  } exp_t;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [2:0] q_pix[$];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RESET_HOLD(2), .CNT_W(32), .PIX_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_cycles(n_cycles),
    .step(step), .halt(halt), .cpu_rst(a_rst), .cpu_ce(a_ce), .pix_ce(a_pix),
    .busy(a_busy), .done(a_done), .cycle_count(a_cnt)
  );

  cpu_run_ctrl #(.RESET_HOLD(2), .CNT_W(4), .PIX_DIV(5)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_cycles(n_cycles[3:0]),
    .step(step), .halt(halt), .cpu_rst(b_rst), .cpu_ce(b_ce), .pix_ce(b_pix),
    .busy(b_busy), .done(b_done), .cycle_count(b_cnt)
  );

  cpu_run_ctrl #(.RESET_HOLD(2), .CNT_W(8), .PIX_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_cycles(n_cycles[7:0]),
    .step(step), .halt(halt), .cpu_rst(c_rst), .cpu_ce(c_ce), .pix_ce(c_pix),
    .busy(c_busy), .done(c_done), .cycle_count(c_cnt)
  );

  task automatic test_reset();
    logic [5:0] ga, gb, gc;
    @(negedge clk);
    ga = {a_rst, a_ce, a_pix, a_busy, a_done, (a_cnt == 32'd0)};
    gb = {b_rst, b_ce, b_pix, b_busy, b_done, (b_cnt == 4'd0)};
    gc = {c_rst, c_ce, c_pix, c_busy, c_done, (c_cnt == 8'd0)};
    checks++;
    if (ga !== 6'b100001) begin
      errors++;
      $display("FAIL reset_a: rst,ce,pix,busy,done,cnt0 got %b exp 100001", ga);
    end
    checks++;
    if (gb !== 6'b100001) begin
      errors++;
      $display("FAIL reset_b: rst,ce,pix,busy,done,cnt0 got %b exp 100001", gb);
    end
    checks++;
    if (gc !== 6'b100001) begin
      errors++;
      $display("FAIL reset_c: rst,ce,pix,busy,done,cnt0 got %b exp 100001", gc);
    end
  endtask

  // Releases reset at a falling edge; t counts rising edges since release.
  task automatic test_pix();
    logic [2:0] e, g;
    for (int t = 0; t < 16; t++) begin
      e[2] = (t >= 1) && (t % 2 == 1);
      e[1] = (t >= 1) && (t % 5 == 4);
      e[0] = (t >= 1);
      q_pix.push_back(e);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t > 0) @(negedge clk);
      g = {a_pix, b_pix, c_pix};
      e = q_pix.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL pix t=%0d: div2,div5,div1 got %b exp %b", t, g, e);
      end
      start = (t == 4);
      mode  = 2'd0;
      halt  = (t == 12);
    end
    start = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic test_run_n18();
    exp_t e, g;
    for (int c = 1; c <= 23; c++) begin
      e.r   = (c <= 2);
      e.ce  = (c >= 3) && (c <= 20);
      e.b   = (c <= 20);
      e.d   = (c >= 21);
      e.cnt = (c < 3) ? 32'd0 : ((c - 3 > 18) ? 32'd18 : 32'(c - 3));
      q_a.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; mode = 2'd2; n_cycles = 32'd18;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      g = {a_rst, a_ce, a_busy, a_done, a_cnt};
      e = q_a.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL run_n18 cyc %0d: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
                 c, g[35:32], g.cnt, e[35:32], e.cnt);
      end
      start = 1'b0; mode = 2'd1; n_cycles = 32'd3;
    end
  endtask

  task automatic test_run_n0();
    exp_t e, g;
    for (int c = 1; c <= 5; c++) begin
      e.r   = (c <= 2);
      e.ce  = 1'b0;
      e.b   = (c <= 2);
      e.d   = (c >= 3);
      e.cnt = 32'd0;
      q_a.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; mode = 2'd2; n_cycles = 32'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      g = {a_rst, a_ce, a_busy, a_done, a_cnt};
      e = q_a.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL run_n0 cyc %0d: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
                 c, g[35:32], g.cnt, e[35:32], e.cnt);
      end
      start = 1'b0;
    end
  endtask

  // Steps at 4, 5 (during a pulse, dropped), 8, 12; step with halt at 16.
  task automatic test_step();
    exp_t e, g;
    for (int c = 1; c <= 19; c++) begin
      e.r   = (c <= 2);
      e.ce  = (c == 5) || (c == 9) || (c == 13);
      e.b   = (c <= 16);
      e.d   = (c >= 17);
      e.cnt = 32'(c > 5) + 32'(c > 9) + 32'(c > 13);
      q_a.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; mode = 2'd1; n_cycles = 32'd7;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      g = {a_rst, a_ce, a_busy, a_done, a_cnt};
      e = q_a.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL step cyc %0d: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
                 c, g[35:32], g.cnt, e[35:32], e.cnt);
      end
      start = 1'b0; mode = 2'd2; n_cycles = 32'd1;
      step  = (c == 4) || (c == 5) || (c == 8) || (c == 12) || (c == 16);
      halt  = (c == 16);
    end
    step = 1'b0;
    halt = 1'b0;
  endtask

  // FREE run; the 4-bit instance saturates at 15, a second start at 10 is ignored.
  task automatic test_free_sat();
    exp_t e, g;
    for (int c = 1; c <= 24; c++) begin
      e.r   = (c <= 2);
      e.ce  = (c >= 3) && (c <= 22);
      e.b   = (c <= 22);
      e.d   = (c >= 23);
      e.cnt = (c < 3) ? 32'd0 : ((c - 3 > 20) ? 32'd20 : 32'(c - 3));
      q_a.push_back(e);
      e.cnt = (e.cnt > 32'd15) ? 32'd15 : e.cnt;
      q_b.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; mode = 2'd0; n_cycles = 32'd2;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      g = {a_rst, a_ce, a_busy, a_done, a_cnt};
      e = q_a.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL free cyc %0d: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
                 c, g[35:32], g.cnt, e[35:32], e.cnt);
      end
      g = {b_rst, b_ce, b_busy, b_done, 28'd0, b_cnt};
      e = q_b.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL free_sat4 cyc %0d: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
                 c, g[35:32], g.cnt, e[35:32], e.cnt);
      end
      start = (c == 10); mode = 2'd2;
      halt  = (c == 22);
    end
    start = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e, g;
    @(negedge clk);
    start = 1'b1; mode = 2'd2; n_cycles = 32'd50;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    g = {a_rst, a_ce, a_busy, a_done, a_cnt};
    e = {1'b0, 1'b1, 1'b1, 1'b0, 32'd2};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL arst_pre: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
               g[35:32], g.cnt, e[35:32], e.cnt);
    end
    #2 rst = 1'b0;
    #1;
    g = {a_rst, a_ce, a_busy, a_done, a_cnt};
    e = {1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    checks++;
    if (g !== e || a_pix !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: r,ce,b,d=%b cnt=%0d pix=%b exp %b cnt=0 pix=0",
               g[35:32], g.cnt, a_pix, e[35:32]);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      g = {a_rst, a_ce, a_busy, a_done, a_cnt};
      checks++;
      if (g !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
        errors++;
        $display("FAIL arst_idle cyc %0d: r,ce,b,d=%b cnt=%0d exp 1000 cnt=0",
                 c, g[35:32], g.cnt);
      end
    end
    for (int c = 1; c <= 5; c++) begin
      e.r   = (c <= 2);
      e.ce  = (c == 3);
      e.b   = (c <= 3);
      e.d   = (c >= 4);
      e.cnt = (c >= 4) ? 32'd1 : 32'd0;
      q_a.push_back(e);
    end
    start = 1'b1; mode = 2'd2; n_cycles = 32'd1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      g = {a_rst, a_ce, a_busy, a_done, a_cnt};
      e = q_a.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL arst_rerun cyc %0d: r,ce,b,d=%b cnt=%0d exp %b cnt=%0d",
                 c, g[35:32], g.cnt, e[35:32], e.cnt);
      end
      start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_pix();
    test_run_n18();
    test_run_n0();
    test_step();
    test_free_sat();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded bound, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
